// File: rtl/urna_pkg.sv
// Shared types and defaults for the urna election-session controller.
package urna_pkg;

  // Session state encoding, also driven out on the state port.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StOpen   = 2'b01,
    StClosed = 2'b10
  } urna_state_e;

  // Classification of an accepted vote.
  typedef enum logic [1:0] {
    KindNull  = 2'b00,
    KindCand1 = 2'b01,
    KindCand2 = 2'b10
  } vote_kind_e;

  localparam logic [7:0] DEF_CAND1_CODE = 8'h13;
  localparam logic [7:0] DEF_CAND2_CODE = 8'h23;

  // Exact match against the two candidate codes; anything else, BCD or not, is null.
  function automatic vote_kind_e classify_code(input logic [7:0] code,
                                               input logic [7:0] c1_code,
                                               input logic [7:0] c2_code);
    vote_kind_e kind;
    if (code == c1_code) begin
      kind = KindCand1;
    end else if (code == c2_code) begin
      kind = KindCand2;
    end else begin
      kind = KindNull;
    end
    return kind;
  endfunction

endpackage

// File: rtl/urna_session_ctrl_if.sv
// Host/booth-facing bundle of the session controller: commands, booth handshake, results.
interface urna_session_ctrl_if #(
  parameter int unsigned N_BOOTHS = 4,
  parameter int unsigned CNT_W    = 8
);

  logic                  open_cmd;
  logic                  close_cmd;
  logic                  clear_cmd;
  logic [N_BOOTHS-1:0]   req;
  logic [8*N_BOOTHS-1:0] code;
  logic [N_BOOTHS-1:0]   gnt;
  logic                  vote_valid;
  logic [1:0]            vote_kind;
  logic [CNT_W-1:0]      cnt_c1;
  logic [CNT_W-1:0]      cnt_c2;
  logic [CNT_W-1:0]      cnt_null;
  logic [1:0]            state;
  logic                  results_valid;
  logic                  sat;

  // Host and booths side.
  modport master (
    output open_cmd, close_cmd, clear_cmd, req, code,
    input  gnt, vote_valid, vote_kind, cnt_c1, cnt_c2, cnt_null, state, results_valid, sat
  );

  // Controller side.
  modport slave (
    input  open_cmd, close_cmd, clear_cmd, req, code,
    output gnt, vote_valid, vote_kind, cnt_c1, cnt_c2, cnt_null, state, results_valid, sat
  );

endinterface

// File: rtl/urna_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the pointer.
module urna_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_req_eligible,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_index
);

  logic [IdxW-1:0] r_ptr;

  // Scan downward so the eligible requester closest to the pointer is written last and wins.
  always_comb begin
    int pos;
    pos     = 0;
    o_grant = '0;
    o_index = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = (int'(r_ptr) + k) % int'(N);
      if (i_req_eligible[pos]) begin
        o_grant      = '0;
        o_grant[pos] = 1'b1;
        o_index      = IdxW'(pos);
      end
    end
  end

  // Pointer moves to the booth after the one just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= IdxW'((int'(o_index) + 1) % int'(N));
    end
  end

endmodule

// File: rtl/urna_session_ctrl.sv
// Election-session controller: arbitrates booths onto one tally, classifies and counts
// votes, and sequences IDLE -> OPEN -> CLOSED with an optional inactivity timeout.
module urna_session_ctrl
  import urna_pkg::*;
#(
  parameter int unsigned N_BOOTHS    = 4,
  parameter int unsigned CNT_W       = 8,
  parameter logic [7:0]  CAND1_CODE  = DEF_CAND1_CODE,
  parameter logic [7:0]  CAND2_CODE  = DEF_CAND2_CODE,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic                clk,
  input logic                rst_n,
  urna_session_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (N_BOOTHS > 1) ? $clog2(N_BOOTHS) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0]  TmoLast = TmoW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  localparam logic [1:0] S_IDLE   = StIdle;
  localparam logic [1:0] S_OPEN   = StOpen;
  localparam logic [1:0] S_CLOSED = StClosed;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [N_BOOTHS-1:0]   r_req;
  logic [8*N_BOOTHS-1:0] r_code;
  logic [N_BOOTHS-1:0]   r_lock;
  logic [N_BOOTHS-1:0]   w_lock_nxt;
  logic [N_BOOTHS-1:0]   r_gnt;
  logic                  r_vote_valid;
  logic [1:0]            r_vote_kind;
  logic [CNT_W-1:0]      r_cnt_c1;
  logic [CNT_W-1:0]      r_cnt_c2;
  logic [CNT_W-1:0]      r_cnt_null;
  logic [CNT_W-1:0]      w_c1_nxt;
  logic [CNT_W-1:0]      w_c2_nxt;
  logic [CNT_W-1:0]      w_null_nxt;
  logic                  r_sat;
  logic                  w_sat_nxt;
  logic                  r_results_valid;
  logic [TmoW-1:0]       r_idle;

  logic                  w_open;
  logic [N_BOOTHS-1:0]   w_elig;
  logic [N_BOOTHS-1:0]   w_arb_grant;
  logic [IdxW-1:0]       w_arb_idx;
  logic                  w_accept;
  logic                  w_timeout;
  logic [7:0]            w_code;
  vote_kind_e            w_kind;

  assign w_open = (r_state == S_OPEN);
  assign w_elig = r_req & ~r_lock & {N_BOOTHS{w_open}};

  // A close or clear in the same cycle pre-empts any grant; the booth stays ungranted.
  assign w_accept  = w_open && (|w_elig) && !bus.close_cmd && !bus.clear_cmd;
  assign w_timeout = (TIMEOUT_CYC != 0) && w_open && !w_accept && (r_idle == TmoLast);

  assign w_code = r_code[int'(w_arb_idx) * 8 +: 8];
  assign w_kind = classify_code(w_code, CAND1_CODE, CAND2_CODE);

  urna_rr_arbiter #(
    .N (N_BOOTHS)
  ) u_arbiter (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_eligible (w_elig),
    .i_advance      (w_accept),
    .o_grant        (w_arb_grant),
    .o_index        (w_arb_idx)
  );

  // Session FSM next state; clear overrides everything, illegal commands fall through.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_cmd) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.open_cmd) w_state_nxt = S_OPEN;
        S_OPEN:   if (bus.close_cmd || w_timeout) w_state_nxt = S_CLOSED;
        S_CLOSED: w_state_nxt = S_CLOSED;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A booth stays locked until its req has been seen low; outside OPEN all locks drop.
  always_comb begin
    w_lock_nxt = '0;
    if (w_open) begin
      w_lock_nxt = r_lock & r_req;
      if (w_accept) begin
        w_lock_nxt = w_lock_nxt | w_arb_grant;
      end
    end
  end

  // Saturating tallies; an increment attempted at full scale raises the sticky flag.
  always_comb begin
    w_c1_nxt   = r_cnt_c1;
    w_c2_nxt   = r_cnt_c2;
    w_null_nxt = r_cnt_null;
    w_sat_nxt  = r_sat;
    if (bus.clear_cmd) begin
      w_c1_nxt   = '0;
      w_c2_nxt   = '0;
      w_null_nxt = '0;
      w_sat_nxt  = 1'b0;
    end else if (w_accept) begin
      case (w_kind)
        KindCand1: begin
          if (r_cnt_c1 == CntMax) w_sat_nxt = 1'b1;
          else                    w_c1_nxt  = r_cnt_c1 + 1'b1;
        end
        KindCand2: begin
          if (r_cnt_c2 == CntMax) w_sat_nxt = 1'b1;
          else                    w_c2_nxt  = r_cnt_c2 + 1'b1;
        end
        default: begin
          if (r_cnt_null == CntMax) w_sat_nxt  = 1'b1;
          else                      w_null_nxt = r_cnt_null + 1'b1;
        end
      endcase
    end
  end

  // Session state, booth input sampling and lock bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_results_valid <= 1'b0;
      r_req           <= '0;
      r_code          <= '0;
      r_lock          <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_results_valid <= (w_state_nxt == S_CLOSED);
      r_req           <= bus.req;
      r_code          <= bus.code;
      r_lock          <= w_lock_nxt;
    end
  end

  // Registered grant pulse, vote classification and tallies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt        <= '0;
      r_vote_valid <= 1'b0;
      r_vote_kind  <= KindNull;
      r_cnt_c1     <= '0;
      r_cnt_c2     <= '0;
      r_cnt_null   <= '0;
      r_sat        <= 1'b0;
    end else begin
      r_gnt        <= w_accept ? w_arb_grant : '0;
      r_vote_valid <= w_accept;
      if (w_accept) begin
        r_vote_kind <= w_kind;
      end
      r_cnt_c1   <= w_c1_nxt;
      r_cnt_c2   <= w_c2_nxt;
      r_cnt_null <= w_null_nxt;
      r_sat      <= w_sat_nxt;
    end
  end

  // Inactivity counter: zero outside OPEN and on every grant, so entering OPEN starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_open || w_accept) begin
      r_idle <= '0;
    end else if (TIMEOUT_CYC != 0) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.vote_valid    = r_vote_valid;
  assign bus.vote_kind     = r_vote_kind;
  assign bus.cnt_c1        = r_cnt_c1;
  assign bus.cnt_c2        = r_cnt_c2;
  assign bus.cnt_null      = r_cnt_null;
  assign bus.state         = r_state;
  assign bus.results_valid = r_results_valid;
  assign bus.sat           = r_sat;

endmodule

// File: tb/tb_urna_session_ctrl.sv
// Bench for urna_session_ctrl: scoreboarded votes, a classification table and
// hand-written sequences for latency, saturation, close, timeout and reset.
module tb_urna_session_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned TMO = 10;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] kind;
  } exp_t;

  typedef struct {
    int         booth;
    logic [7:0] code;
    logic [1:0] kind;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t exp_q[$];

  urna_session_ctrl_if #(.N_BOOTHS(NB), .CNT_W(CW)) bus ();

  urna_session_ctrl #(
    .N_BOOTHS    (NB),
    .CNT_W       (CW),
    .CAND1_CODE  (8'h13),
    .CAND2_CODE  (8'h23),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.open_cmd  = 1'b0;
    bus.close_cmd = 1'b0;
    bus.clear_cmd = 1'b0;
    bus.req       = '0;
    bus.code      = '0;
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_open();
    bus.open_cmd = 1'b1;
    tick(1);
    bus.open_cmd = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_cmd = 1'b1;
    tick(1);
    bus.clear_cmd = 1'b0;
  endtask

  // Waits a bounded number of cycles for booth b's grant; returns cycles taken or -1.
  task automatic wait_gnt(input int b, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (bus.gnt[b]) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: booth %0d got no grant within 8 cycles", b);
    end
  endtask

  task automatic vote(input int b, input logic [7:0] code, input logic [1:0] kind);
    exp_t e;
    int   cyc;
    e.gnt             = 4'(1 << b);
    e.kind            = kind;
    bus.code[b*8 +: 8] = code;
    bus.req[b]        = 1'b1;
    exp_q.push_back(e);
    wait_gnt(b, cyc);
    bus.req[b] = 1'b0;
    tick(2);
  endtask

  // Scoreboard side: every vote_valid must match the oldest expected grant.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.vote_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vote: got gnt=%0h with no vote pending", bus.gnt);
        end else begin
          e = exp_q.pop_front();
          check("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
          check("sb_kind", 32'(bus.vote_kind), 32'(e.kind));
        end
      end else if (bus.gnt != '0) begin
        total++;
        bad++;
        $display("FAIL gnt_without_valid: got gnt=%0h want 0", bus.gnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   exp_c1, exp_c2, exp_n;
    int   first, last, nseen, cyc, closed_at;

    total = 0;
    bad   = 0;
    vecs[0] = '{booth: 1, code: 8'h13, kind: 2'b01};
    vecs[1] = '{booth: 2, code: 8'h23, kind: 2'b10};
    vecs[2] = '{booth: 3, code: 8'h99, kind: 2'b00};
    vecs[3] = '{booth: 0, code: 8'h00, kind: 2'b00};
    vecs[4] = '{booth: 1, code: 8'h31, kind: 2'b00};
    vecs[5] = '{booth: 2, code: 8'h1F, kind: 2'b00};
    vecs[6] = '{booth: 3, code: 8'h3A, kind: 2'b00};
    vecs[7] = '{booth: 0, code: 8'h23, kind: 2'b10};

    // Reset state.
    do_reset();
    check("rst_state", 32'(bus.state), 0);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_valid", 32'(bus.vote_valid), 0);
    check("rst_kind", 32'(bus.vote_kind), 0);
    check("rst_cnts", {bus.cnt_c1, bus.cnt_c2, bus.cnt_null}, 0);
    check("rst_rv_sat", {bus.results_valid, bus.sat}, 0);

    // Single vote latency and no double vote on a held req.
    pulse_open();
    check("t1_open", 32'(bus.state), 1);
    bus.code[7:0] = 8'h13;
    bus.req[0]    = 1'b1;
    e.gnt  = 4'b0001;
    e.kind = 2'b01;
    exp_q.push_back(e);
    tick(1);
    check("t1_gnt_early", 32'(bus.gnt), 0);
    tick(1);
    check("t1_gnt", 32'(bus.gnt), 1);
    check("t1_kind", 32'(bus.vote_kind), 1);
    check("t1_c1", 32'(bus.cnt_c1), 1);
    tick(5);
    check("t1_c1_held", 32'(bus.cnt_c1), 1);
    bus.req[0] = 1'b0;
    tick(2);

    // All four booths at once: served 0,1,2,3 on consecutive cycles.
    do_reset();
    pulse_open();
    bus.code = {8'h13, 8'h99, 8'h23, 8'h13};
    bus.req  = 4'hF;
    for (int b = 0; b < 4; b++) begin
      e.gnt  = 4'(1 << b);
      e.kind = (b == 1) ? 2'b10 : ((b == 2) ? 2'b00 : 2'b01);
      exp_q.push_back(e);
    end
    first = -1;
    last  = -1;
    nseen = 0;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      if (bus.gnt != '0) begin
        if (first < 0) first = c;
        last = c;
        nseen++;
        bus.req = bus.req & ~bus.gnt;
      end
    end
    check("t2_ngrants", 32'(nseen), 4);
    check("t2_first", 32'(first), 2);
    check("t2_span", 32'(last - first), 3);
    check("t2_c1", 32'(bus.cnt_c1), 2);
    check("t2_c2", 32'(bus.cnt_c2), 1);
    check("t2_null", 32'(bus.cnt_null), 1);

    // Classification table, one booth at a time.
    exp_c1 = 2;
    exp_c2 = 1;
    exp_n  = 1;
    for (int i = 0; i < 8; i++) begin
      vote(vecs[i].booth, vecs[i].code, vecs[i].kind);
      if (vecs[i].kind == 2'b01) exp_c1++;
      else if (vecs[i].kind == 2'b10) exp_c2++;
      else exp_n++;
    end
    check("tab_c1", 32'(bus.cnt_c1), 32'(exp_c1));
    check("tab_c2", 32'(bus.cnt_c2), 32'(exp_c2));
    check("tab_null", 32'(bus.cnt_null), 32'(exp_n));

    // Saturation of a 4-bit counter.
    do_reset();
    pulse_open();
    for (int i = 0; i < 15; i++) vote(0, 8'h13, 2'b01);
    check("t3_c1_15", 32'(bus.cnt_c1), 15);
    check("t3_sat_before", 32'(bus.sat), 0);
    vote(0, 8'h13, 2'b01);
    check("t3_c1_sat", 32'(bus.cnt_c1), 15);
    check("t3_sat", 32'(bus.sat), 1);
    vote(0, 8'h13, 2'b01);
    check("t3_c1_hold", 32'(bus.cnt_c1), 15);
    check("t3_state", 32'(bus.state), 1);

    // Close in the same cycle as a booth 2 request: close wins, no grant.
    bus.code[23:16] = 8'h23;
    bus.req[2]      = 1'b1;
    bus.close_cmd   = 1'b1;
    tick(1);
    bus.close_cmd = 1'b0;
    check("t4_state", 32'(bus.state), 2);
    check("t4_rv", 32'(bus.results_valid), 1);
    tick(3);
    check("t4_counts", {bus.cnt_c1, bus.cnt_c2, bus.cnt_null}, 32'({4'd15, 4'd0, 4'd0}));
    check("t4_sat_hold", 32'(bus.sat), 1);
    bus.req[2] = 1'b0;
    pulse_clear();
    check("t4_clear_state", 32'(bus.state), 0);
    check("t4_clear_cnts", {bus.cnt_c1, bus.sat, bus.results_valid}, 0);

    // Inactivity timeout closes exactly TMO cycles after open.
    pulse_open();
    closed_at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (bus.state == 2'b10 && closed_at < 0) closed_at = k;
    end
    check("t5_timeout", 32'(closed_at), TMO);
    check("t5_rv", 32'(bus.results_valid), 1);
    pulse_clear();
    check("t5_idle", 32'(bus.state), 0);
    check("t5_cnts", {bus.cnt_c1, bus.cnt_c2, bus.cnt_null}, 0);

    // Asynchronous reset while a grant is showing.
    do_reset();
    pulse_open();
    bus.code[15:8] = 8'h99;
    bus.req[1]     = 1'b1;
    wait_gnt(1, cyc);
    check("t6_null_pre", 32'(bus.cnt_null), 1);
    rst_n = 1'b0;
    #1;
    check("t6_gnt_rst", 32'(bus.gnt), 0);
    check("t6_null_rst", 32'(bus.cnt_null), 0);
    check("t6_state_rst", 32'(bus.state), 0);
    bus.req[1] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Commands illegal for the current state are ignored.
    bus.close_cmd = 1'b1;
    tick(1);
    bus.close_cmd = 1'b0;
    check("t6_close_in_idle", 32'(bus.state), 0);
    pulse_open();
    pulse_open();
    check("t6_open_in_open", 32'(bus.state), 1);
    pulse_clear();
    check("t6_clear_open", 32'(bus.state), 0);

    tick(2);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
